// File: rtl/icb_sram_responder.sv
// ICB responder backed by a word-addressed scratch SRAM.
// Responses are queued in order and released after a fixed minimum latency.
module icb_sram_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int unsigned MEM_DEPTH = 64,
    parameter int unsigned RSP_LAT   = 1,
    parameter int unsigned OSTD      = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        icb_cmd_valid,
    output logic        icb_cmd_ready,
    input  logic [31:0] icb_cmd_addr,
    input  logic        icb_cmd_read,
    input  logic [31:0] icb_cmd_wdata,
    input  logic [3:0]  icb_cmd_wmask,
    input  logic [1:0]  icb_cmd_burst,
    input  logic [1:0]  icb_cmd_beat,
    input  logic        icb_cmd_lock,
    input  logic        icb_cmd_excl,
    input  logic [1:0]  icb_cmd_size,
    output logic        icb_rsp_valid,
    input  logic        icb_rsp_ready,
    output logic        icb_rsp_err,
    output logic        icb_rsp_excl_ok,
    output logic [31:0] icb_rsp_rdata
);

    localparam int unsigned AW     = $clog2(MEM_DEPTH);
    localparam int unsigned CW     = $clog2(OSTD + 1);
    localparam logic [2:0]  LAT    = 3'(RSP_LAT);
    localparam logic [CW-1:0] OSTD_C = CW'(OSTD);

    typedef struct packed {
        logic        err;
        logic        excl_ok;
        logic [31:0] rdata;
        logic [2:0]  age;
    } ent_t;

    logic [31:0]   mem_q [MEM_DEPTH];
    logic [31:0]   mem_d [MEM_DEPTH];
    ent_t          ent_q [OSTD];
    ent_t          ent_d [OSTD];
    ent_t          aged  [OSTD];
    ent_t          new_ent;
    logic [CW-1:0] cnt_q, cnt_d, wr_slot;
    logic          cmd_ready_q;
    logic          res_valid_q, res_valid_d;
    logic [AW-1:0] res_idx_q, res_idx_d;

    logic [31:0]   off;
    logic          in_range, cmd_err, push, pop, do_write;
    logic [AW-1:0] idx;
    logic          unused_inputs;

    assign unused_inputs = ^{icb_cmd_beat, icb_cmd_lock};

    // Subtraction wraps, so addresses below the base land far out of range.
    assign off      = icb_cmd_addr - BASE_ADDR;
    assign in_range = off < 32'(MEM_DEPTH * 4);
    assign idx      = off[AW+1:2];
    assign cmd_err  = !in_range || (icb_cmd_burst != 2'd0) || (icb_cmd_size == 2'd3) ||
                      ((icb_cmd_size == 2'd1) && icb_cmd_addr[0]) ||
                      ((icb_cmd_size == 2'd2) && (icb_cmd_addr[1:0] != 2'd0));

    assign icb_cmd_ready   = cmd_ready_q;
    assign push            = icb_cmd_valid & cmd_ready_q;
    assign icb_rsp_valid   = (cnt_q != '0) && (ent_q[0].age >= LAT);
    assign pop             = icb_rsp_valid & icb_rsp_ready;
    assign icb_rsp_err     = icb_rsp_valid & ent_q[0].err;
    assign icb_rsp_excl_ok = icb_rsp_valid & ent_q[0].excl_ok;
    assign icb_rsp_rdata   = icb_rsp_valid ? ent_q[0].rdata : 32'h0;

    always_comb begin
        mem_d         = mem_q;
        res_valid_d   = res_valid_q;
        res_idx_d     = res_idx_q;
        do_write      = 1'b0;
        new_ent       = '0;
        new_ent.age   = 3'd1;
        new_ent.err   = cmd_err;
        if (push && !cmd_err) begin
            if (icb_cmd_read) begin
                new_ent.rdata = mem_q[idx];
                if (icb_cmd_excl) begin
                    res_valid_d     = 1'b1;
                    res_idx_d       = idx;
                    new_ent.excl_ok = 1'b1;
                end
            end else if (icb_cmd_excl) begin
                if (res_valid_q && (res_idx_q == idx)) begin
                    do_write        = 1'b1;
                    new_ent.excl_ok = 1'b1;
                    res_valid_d     = 1'b0;
                end
            end else begin
                do_write = 1'b1;
                if (res_valid_q && (res_idx_q == idx)) begin
                    res_valid_d = 1'b0;
                end
            end
        end
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (icb_cmd_wmask[b]) begin
                    mem_d[idx][8*b +: 8] = icb_cmd_wdata[8*b +: 8];
                end
            end
        end
    end

    // Every slot ages each cycle; new entries start at 1 to count the accepting edge.
    always_comb begin
        for (int i = 0; i < int'(OSTD); i++) begin
            aged[i] = ent_q[i];
            if (aged[i].age < LAT) begin
                aged[i].age = aged[i].age + 3'd1;
            end
        end
        ent_d   = aged;
        cnt_d   = cnt_q;
        wr_slot = cnt_q;
        if (pop) begin
            for (int i = 0; i < int'(OSTD) - 1; i++) begin
                ent_d[i] = aged[i+1];
            end
            ent_d[OSTD-1] = '0;
            cnt_d         = cnt_q - CW'(1);
            wr_slot       = cnt_q - CW'(1);
        end
        if (push) begin
            for (int i = 0; i < int'(OSTD); i++) begin
                if (CW'(i) == wr_slot) begin
                    ent_d[i] = new_ent;
                end
            end
            cnt_d = cnt_d + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(MEM_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            for (int i = 0; i < int'(OSTD); i++) begin
                ent_q[i] <= '0;
            end
            cnt_q       <= '0;
            cmd_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_idx_q   <= '0;
        end else begin
            mem_q       <= mem_d;
            ent_q       <= ent_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cnt_d < OSTD_C;
            res_valid_q <= res_valid_d;
            res_idx_q   <= res_idx_d;
        end
    end

endmodule

// File: tb/tb_icb_sram_responder.sv
// Bench for icb_sram_responder: directed vector table, backpressure and reset
// sequences, then random traffic against a queue/array reference model.
module tb_icb_sram_responder;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned LAT   = 1;
    localparam int unsigned OSTD  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_read, cmd_lock, cmd_excl;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wmask;
    logic [1:0]  cmd_burst, cmd_beat, cmd_size;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_excl_ok;
    logic [31:0] rsp_rdata;

    always #5 clk = ~clk;

    icb_sram_responder #(
        .BASE_ADDR (BASE),
        .MEM_DEPTH (DEPTH),
        .RSP_LAT   (LAT),
        .OSTD      (OSTD)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .icb_cmd_valid   (cmd_valid),
        .icb_cmd_ready   (cmd_ready),
        .icb_cmd_addr    (cmd_addr),
        .icb_cmd_read    (cmd_read),
        .icb_cmd_wdata   (cmd_wdata),
        .icb_cmd_wmask   (cmd_wmask),
        .icb_cmd_burst   (cmd_burst),
        .icb_cmd_beat    (cmd_beat),
        .icb_cmd_lock    (cmd_lock),
        .icb_cmd_excl    (cmd_excl),
        .icb_cmd_size    (cmd_size),
        .icb_rsp_valid   (rsp_valid),
        .icb_rsp_ready   (rsp_ready),
        .icb_rsp_err     (rsp_err),
        .icb_rsp_excl_ok (rsp_excl_ok),
        .icb_rsp_rdata   (rsp_rdata)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: memory image, reservation, expected response queue.
    typedef struct {
        logic        err;
        logic        ok;
        logic [31:0] rdata;
        int          acc;
    } exp_t;
    exp_t        q[$];
    logic [31:0] mem_m [DEPTH];
    logic        res_v;
    int unsigned res_i;

    logic        last_acc, last_pop, pop_err, pop_ok;
    logic [31:0] pop_rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_exec(output logic e, output logic ok, output logic [31:0] rd);
        logic [31:0] off;
        int unsigned i;
        off = cmd_addr - BASE;
        e = (off >= DEPTH * 4) || (cmd_burst != 0) || (cmd_size == 3) ||
            (cmd_size == 1 && cmd_addr[0]) || (cmd_size == 2 && cmd_addr[1:0] != 0);
        ok = 0;
        rd = 0;
        if (e) return;
        i = off / 4;
        if (cmd_read) begin
            rd = mem_m[i];
            if (cmd_excl) begin
                res_v = 1; res_i = i; ok = 1;
            end
            return;
        end
        if (cmd_excl) begin
            if (!(res_v && res_i == i)) return;
            ok = 1;
            res_v = 0;
        end else if (res_v && res_i == i) begin
            res_v = 0;
        end
        for (int b = 0; b < 4; b++)
            if (cmd_wmask[b]) mem_m[i][8*b +: 8] = cmd_wdata[8*b +: 8];
    endtask

    // One clock: check outputs at negedge, update model for edge handshakes.
    task automatic step();
        exp_t e;
        logic exp_v;
        @(negedge clk);
        last_acc = 0;
        last_pop = 0;
        check("cmd_ready", cmd_ready, (q.size() < OSTD));
        exp_v = (q.size() > 0) && ((cyc - q[0].acc) >= LAT);
        check("rsp_valid", rsp_valid, exp_v);
        if (!rsp_valid) check("idle rsp fields", {rsp_err, rsp_excl_ok, rsp_rdata}, 0);
        if (rsp_valid && rsp_ready && q.size() > 0) begin
            e = q.pop_front();
            check("rsp err", rsp_err, e.err);
            check("rsp excl_ok", rsp_excl_ok, e.ok);
            check("rsp rdata", rsp_rdata, e.rdata);
            last_pop = 1;
            pop_err = rsp_err; pop_ok = rsp_excl_ok; pop_rdata = rsp_rdata;
        end
        if (cmd_valid && cmd_ready) begin
            model_exec(e.err, e.ok, e.rdata);
            e.acc = cyc;
            q.push_back(e);
            last_acc = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic rd, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] m, input logic ex);
        cmd_valid = 1; cmd_read = rd; cmd_addr = a; cmd_wdata = wd; cmd_wmask = m;
        cmd_excl = ex; cmd_size = 2; cmd_burst = 0;
    endtask

    task automatic wait_acc(input string name);
        for (int k = 0; k < 20; k++) begin
            step();
            if (last_acc) break;
        end
        check(name, last_acc, 1);
        cmd_valid = 0;
    endtask

    task automatic drain();
        rsp_ready = 1;
        cmd_valid = 0;
        for (int k = 0; k < 30 && q.size() > 0; k++) step();
        check("drain empty", q.size(), 0);
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 0;
        res_v = 0;
        res_i = 0;
        q.delete();
    endtask

    task automatic do_reset(input int n);
        rst_n = 0;
        cmd_valid = 0;
        repeat (n) @(posedge clk);
        #1;
        check("reset cmd_ready", cmd_ready, 0);
        check("reset rsp", {rsp_valid, rsp_err, rsp_excl_ok, rsp_rdata}, 0);
        rst_n = 1;
        model_clear();
        @(negedge clk);
        check("post-reset rsp_valid", rsp_valid, 0);
        @(posedge clk);
        #1;
        check("cmd_ready after release", cmd_ready, 1);
        check("rsp_valid after release", rsp_valid, 0);
    endtask

    typedef struct {
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [1:0]  burst;
        logic [1:0]  size;
        logic        excl;
        logic        e_err;
        logic        e_ok;
        logic [31:0] e_rdata;
    } vec_t;

    function automatic vec_t mk(logic rd, logic [31:0] off, logic [31:0] wd, logic [3:0] m,
                                logic [1:0] bu, logic [1:0] sz, logic ex, logic ee,
                                logic eo, logic [31:0] er);
        vec_t v;
        v.rd = rd; v.addr = BASE + off; v.wdata = wd; v.mask = m; v.burst = bu;
        v.size = sz; v.excl = ex; v.e_err = ee; v.e_ok = eo; v.e_rdata = er;
        return v;
    endfunction

    vec_t vecs[20];

    initial begin
        int pi, ai;
        vecs[0]  = mk(0, 32'h08, 32'hDEADBEEF, 4'hF, 0, 2, 0, 0, 0, 32'h0);
        vecs[1]  = mk(1, 32'h08, 32'h0,        4'h0, 0, 2, 0, 0, 0, 32'hDEADBEEF);
        vecs[2]  = mk(0, 32'h0C, 32'h11223344, 4'h5, 0, 2, 0, 0, 0, 32'h0);
        vecs[3]  = mk(1, 32'h0C, 32'h0,        4'h0, 0, 2, 0, 0, 0, 32'h00220044);
        vecs[4]  = mk(1, 32'h100, 32'h0,       4'h0, 0, 2, 0, 1, 0, 32'h0);
        vecs[5]  = mk(0, 32'h100, 32'h12345678, 4'hF, 0, 2, 0, 1, 0, 32'h0);
        vecs[6]  = mk(1, 32'h00, 32'h0,        4'h0, 0, 2, 0, 0, 0, 32'h0);
        vecs[7]  = mk(1, 32'h02, 32'h0,        4'h0, 0, 2, 0, 1, 0, 32'h0);
        vecs[8]  = mk(1, 32'h08, 32'h0,        4'h0, 1, 2, 0, 1, 0, 32'h0);
        vecs[9]  = mk(1, 32'h10, 32'h0,        4'h0, 0, 2, 1, 0, 1, 32'h0);
        vecs[10] = mk(0, 32'h10, 32'hA5A5A5A5, 4'hF, 0, 2, 1, 0, 1, 32'h0);
        vecs[11] = mk(1, 32'h10, 32'h0,        4'h0, 0, 2, 0, 0, 0, 32'hA5A5A5A5);
        vecs[12] = mk(1, 32'h10, 32'h0,        4'h0, 0, 2, 1, 0, 1, 32'hA5A5A5A5);
        vecs[13] = mk(0, 32'h10, 32'h1,        4'hF, 0, 2, 0, 0, 0, 32'h0);
        vecs[14] = mk(0, 32'h10, 32'hFF,       4'hF, 0, 2, 1, 0, 0, 32'h0);
        vecs[15] = mk(1, 32'h10, 32'h0,        4'h0, 0, 2, 0, 0, 0, 32'h1);
        vecs[16] = mk(1, 32'h04, 32'h0,        4'h0, 0, 3, 0, 1, 0, 32'h0);
        vecs[17] = mk(1, 32'h01, 32'h0,        4'h0, 0, 1, 0, 1, 0, 32'h0);
        vecs[18] = mk(1, 32'h02, 32'h0,        4'h0, 0, 1, 0, 0, 0, 32'h0);
        vecs[19] = mk(1, 32'hFFFF_FFFC, 32'h0, 4'h0, 0, 2, 0, 1, 0, 32'h0);

        rst_n = 0; cmd_valid = 0; cmd_read = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wmask = 0;
        cmd_burst = 0; cmd_beat = 0; cmd_lock = 0; cmd_excl = 0; cmd_size = 2; rsp_ready = 1;
        do_reset(2);

        // Directed vectors, one command at a time.
        foreach (vecs[n]) begin
            set_cmd(vecs[n].rd, vecs[n].addr, vecs[n].wdata, vecs[n].mask, vecs[n].excl);
            cmd_burst = vecs[n].burst;
            cmd_size  = vecs[n].size;
            rsp_ready = 1;
            wait_acc($sformatf("vec%0d accept", n));
            for (int k = 0; k < 20; k++) begin
                step();
                if (last_pop) break;
            end
            check($sformatf("vec%0d rsp seen", n), last_pop, 1);
            check($sformatf("vec%0d err", n), pop_err, vecs[n].e_err);
            check($sformatf("vec%0d excl_ok", n), pop_ok, vecs[n].e_ok);
            check($sformatf("vec%0d rdata", n), pop_rdata, vecs[n].e_rdata);
        end

        // Backpressure: two accepted, third held until a slot frees.
        rsp_ready = 0;
        set_cmd(0, BASE + 32'h20, 32'hCAFE0001, 4'hF, 0);
        wait_acc("bp accept 1");
        set_cmd(0, BASE + 32'h24, 32'hCAFE0002, 4'hF, 0);
        wait_acc("bp accept 2");
        set_cmd(1, BASE + 32'h20, 32'h0, 4'h0, 0);
        repeat (3) begin
            step();
            check("bp third held", last_acc, 0);
        end
        rsp_ready = 1;
        pi = -1; ai = -1;
        for (int k = 0; k < 10 && ai < 0; k++) begin
            step();
            if (last_pop && pi < 0) pi = k;
            if (last_acc) begin
                ai = k;
                cmd_valid = 0;
            end
        end
        check("bp accept after first pop", ai, pi + 1);
        drain();

        // Reset with two responses pending.
        set_cmd(0, BASE + 32'h30, 32'h5555AAAA, 4'hF, 0);
        wait_acc("pre-reset write");
        drain();
        rsp_ready = 0;
        set_cmd(1, BASE + 32'h30, 32'h0, 4'h0, 0);
        wait_acc("pending 1");
        set_cmd(1, BASE + 32'h30, 32'h0, 4'h0, 0);
        wait_acc("pending 2");
        step();
        check("two pending valid", rsp_valid, 1);
        do_reset(1);
        rsp_ready = 1;
        repeat (3) step();
        set_cmd(1, BASE + 32'h30, 32'h0, 4'h0, 0);
        wait_acc("post-reset read");
        for (int k = 0; k < 10 && !last_pop; k++) step();
        check("post-reset read seen", last_pop, 1);
        check("post-reset rdata", pop_rdata, 0);

        // Random traffic checked by the model inside step().
        for (int n = 0; n < 600; n++) begin
            cmd_valid = ($urandom_range(0, 9) < 7);
            cmd_read  = $urandom_range(0, 1);
            cmd_addr  = BASE + $urandom_range(0, 7) * 4;
            if ($urandom_range(0, 9) == 0) cmd_addr = BASE + 32'h100 + $urandom_range(0, 255);
            cmd_size  = 2;
            if ($urandom_range(0, 9) == 0) begin
                cmd_size = $urandom_range(0, 3);
                cmd_addr = cmd_addr + $urandom_range(0, 3);
            end
            cmd_burst = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            cmd_wdata = $urandom;
            cmd_wmask = $urandom_range(0, 15);
            cmd_excl  = ($urandom_range(0, 4) == 0);
            cmd_beat  = $urandom_range(0, 3);
            cmd_lock  = $urandom_range(0, 1);
            rsp_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
